// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory arbiter.
//   - FSM state codes (IDLE, OWN_M)
//   - port ids (PORT_C = core LSU, PORT_M = MAC engine)
//   - default memory depth and the request bundle struct
package dmem_pkg;

  localparam int DEPTH_DEF = 513;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OWN_M = 1'b1;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_M = 1'b1;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  // Full 32-bit compare: the upper address bits only matter for this test.
  function automatic logic in_range(input logic [31:0] a, input int depth);
    return a < 32'(depth);
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: combinational 2-way round-robin selector.
//   i_req     [1:0] request per port (index PORT_C / PORT_M)
//   i_last          port that received the most recent grant
//   i_force_c       C wins if requesting (burst budget exhausted)
//   i_force_m       M wins if requesting (M holds the lock)
//   o_gnt     [1:0] one-hot grant, zero when nothing requests
module dmem_rr_pick
  import dmem_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  input  logic       i_force_m,
  input  logic       i_force_c,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = '0;
    if (i_force_c && i_req[PORT_C])      o_gnt[PORT_C] = 1'b1;
    else if (i_force_m && i_req[PORT_M]) o_gnt[PORT_M] = 1'b1;
    // Conflict: the port that did not win last time goes now.
    else if (&i_req)                     o_gnt[~i_last] = 1'b1;
    else                                 o_gnt = i_req;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the core LSU (C)
// and the MAC engine (M). One access per cycle, round-robin on conflict,
// M may lock the memory for bursts of at most MAX_BURST while C waits.
//   clk, rst                         clock, synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata        core request
//   c_gnt, c_stall                   core grant / stall (combinational)
//   c_rvalid, c_rdata                core read return (registered, 1 cycle)
//   m_req/m_we/m_addr/m_wdata/m_lock MAC request and lock
//   m_gnt, m_rvalid, m_rdata         MAC grant / read return
//   mem_a, mem_wd, mem_we, mem_rd    data memory interface
//   err                              sticky out-of-range flag
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  output logic        c_stall,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic        m_lock,
  output logic        m_gnt,
  output logic        m_rvalid,
  output logic [31:0] m_rdata,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd,
  output logic        err
);

  logic [0:0]       r_state, w_state_nxt;
  logic             r_last;
  logic [CNT_W-1:0] r_burst, w_burst_nxt;
  logic             r_c_rvalid, r_m_rvalid, r_err;
  logic [31:0]      r_c_rdata, r_m_rdata;

  dmem_req_t   w_c, w_m, w_sel;
  logic [1:0]  w_req, w_gnt;
  logic        w_own, w_full, w_oor;
  logic [31:0] w_rd;

  assign w_c = '{req: c_req, we: c_we, addr: c_addr, wdata: c_wdata};
  assign w_m = '{req: m_req, we: m_we, addr: m_addr, wdata: m_wdata};

  // Masking requests during reset forces every grant and the memory drive low.
  assign w_req  = {m_req, c_req} & {2{~rst}};
  assign w_own  = (r_state == OWN_M);
  assign w_full = (r_burst == CNT_W'(MAX_BURST));

  // While owned and locked, M wins; once the burst budget is spent C wins.
  // Without the lock the picker falls back to round-robin, and since last
  // is M in OWN_M a waiting C gets the slot.
  dmem_rr_pick u_pick (
    .i_req    (w_req),
    .i_last   (r_last),
    .i_force_m(w_own & m_lock),
    .i_force_c(w_own & w_full),
    .o_gnt    (w_gnt)
  );

  assign c_gnt   = w_gnt[PORT_C];
  assign m_gnt   = w_gnt[PORT_M];
  assign c_stall = c_req & ~c_gnt;

  always_comb begin
    w_sel = '0;
    if (w_gnt[PORT_C])      w_sel = w_c;
    else if (w_gnt[PORT_M]) w_sel = w_m;
  end

  assign w_oor  = w_sel.req & ~in_range(w_sel.addr, DEPTH);
  assign mem_a  = w_sel.addr;
  assign mem_wd = w_sel.wdata;
  assign mem_we = w_sel.we & ~w_oor;
  assign w_rd   = w_oor ? '0 : mem_rd;

  always_comb begin
    w_state_nxt = r_state;
    w_burst_nxt = r_burst;
    if (r_state == IDLE) begin
      if (w_gnt[PORT_M] && m_lock) begin
        w_state_nxt = OWN_M;
        w_burst_nxt = CNT_W'(1);
      end
    end else if (w_gnt[PORT_M] && m_lock) begin
      // Only count cycles that actually keep C waiting.
      if (c_req) w_burst_nxt = r_burst + 1'b1;
    end else begin
      w_state_nxt = IDLE;
      w_burst_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last     <= PORT_M;
      r_burst    <= '0;
      r_c_rvalid <= 1'b0;
      r_m_rvalid <= 1'b0;
      r_c_rdata  <= '0;
      r_m_rdata  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_burst    <= w_burst_nxt;
      r_c_rvalid <= w_gnt[PORT_C] & ~c_we;
      r_m_rvalid <= w_gnt[PORT_M] & ~m_we;
      if (w_gnt[PORT_C] && !c_we) r_c_rdata <= w_rd;
      if (w_gnt[PORT_M] && !m_we) r_m_rdata <= w_rd;
      if (|w_gnt) r_last <= w_gnt[PORT_M];
      if (w_oor)  r_err  <= 1'b1;
    end
  end

  assign c_rvalid = r_c_rvalid;
  assign c_rdata  = r_c_rdata;
  assign m_rvalid = r_m_rvalid;
  assign m_rdata  = r_m_rdata;
  assign err      = r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int DEPTH     = 513;
  localparam int MAX_BURST = 8;

  logic        clk, rst;
  logic        c_req, c_we, m_req, m_we, m_lock;
  logic [31:0] c_addr, c_wdata, m_addr, m_wdata;
  logic        c_gnt, c_rvalid, c_stall, m_gnt, m_rvalid, mem_we, err;
  logic [31:0] c_rdata, m_rdata, mem_a, mem_wd, mem_rd;

  logic [31:0] env_mem   [0:DEPTH-1];
  logic [31:0] model_mem [0:DEPTH-1];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          own = 0, lastm = 1, burst = 0;
  logic        e_crv = 0, e_mrv = 0, e_err = 0;
  logic [31:0] e_crd = 0, e_mrd = 0;
  logic        last_cg, last_mg, last_we;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_stall(c_stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_lock(m_lock), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
    .err(err)
  );

  assign mem_rd = (mem_a < 32'(DEPTH)) ? env_mem[mem_a[9:0]] : 32'hBAD0_BAD0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock cycle: check combinational outputs mid-cycle, advance, then
  // check registered outputs against the model at the following negedge.
  task automatic step();
    int          eg;
    logic [31:0] ea, ewd, rdv;
    logic        ewe, oor, cap_we;
    logic [31:0] cap_a, cap_wd;
    #2;
    if (rst)                                 eg = 0;
    else if (own != 0 && c_req && burst == MAX_BURST) eg = 1;
    else if (own != 0 && m_req && m_lock)    eg = 2;
    else if (c_req && m_req)                 eg = (lastm != 0) ? 1 : 2;
    else if (c_req)                          eg = 1;
    else if (m_req)                          eg = 2;
    else                                     eg = 0;
    ea  = (eg == 1) ? c_addr  : (eg == 2) ? m_addr  : 32'd0;
    ewd = (eg == 1) ? c_wdata : (eg == 2) ? m_wdata : 32'd0;
    oor = (eg != 0) && (ea >= 32'(DEPTH));
    ewe = ((eg == 1 && c_we) || (eg == 2 && m_we)) && !oor;

    n_tests++;
    if ({c_gnt, m_gnt, c_stall} !== {eg == 1, eg == 2, c_req && eg != 1}) begin
      n_fail++;
      $display("FAIL grant t=%0t got gc/gm/st=%b%b%b exp %b%b%b", $time,
               c_gnt, m_gnt, c_stall, eg == 1, eg == 2, c_req && eg != 1);
    end
    n_tests++;
    if ({mem_we, mem_a, mem_wd} !== {ewe, ea, ewd}) begin
      n_fail++;
      $display("FAIL memdrive t=%0t got we=%b a=%h wd=%h exp we=%b a=%h wd=%h",
               $time, mem_we, mem_a, mem_wd, ewe, ea, ewd);
    end
    last_cg = c_gnt; last_mg = m_gnt; last_we = mem_we;
    cap_we = mem_we; cap_a = mem_a; cap_wd = mem_wd;

    @(posedge clk);
    @(negedge clk);
    if (cap_we === 1'b1 && cap_a < 32'(DEPTH)) env_mem[cap_a[9:0]] = cap_wd;

    if (rst) begin
      own = 0; lastm = 1; burst = 0;
      e_crv = 0; e_mrv = 0; e_crd = 0; e_mrd = 0; e_err = 0;
    end else begin
      rdv   = oor ? 32'd0 : model_mem[ea[9:0]];
      e_crv = (eg == 1) && !c_we;
      e_mrv = (eg == 2) && !m_we;
      if (e_crv) e_crd = rdv;
      if (e_mrv) e_mrd = rdv;
      if (oor) e_err = 1;
      if (ewe) model_mem[ea[9:0]] = ewd;
      case (eg)
        1: begin lastm = 0; own = 0; burst = 0; end
        2: begin
          lastm = 1;
          if (own == 0) begin
            if (m_lock) begin own = 1; burst = 1; end
          end else if (!m_lock) begin
            own = 0; burst = 0;
          end else if (c_req) begin
            burst++;
          end
        end
        default: begin own = 0; burst = 0; end
      endcase
    end

    n_tests++;
    if ({c_rvalid, c_rdata} !== {e_crv, e_crd}) begin
      n_fail++;
      $display("FAIL c_read t=%0t got v=%b d=%h exp v=%b d=%h", $time,
               c_rvalid, c_rdata, e_crv, e_crd);
    end
    n_tests++;
    if ({m_rvalid, m_rdata} !== {e_mrv, e_mrd}) begin
      n_fail++;
      $display("FAIL m_read t=%0t got v=%b d=%h exp v=%b d=%h", $time,
               m_rvalid, m_rdata, e_mrv, e_mrd);
    end
    n_tests++;
    if (err !== e_err) begin
      n_fail++;
      $display("FAIL err t=%0t got %b exp %b", $time, err, e_err);
    end
  endtask

  task automatic idle();
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_lock = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; step(); rst = 0;
  endtask

  task automatic test_reset();
    c_req = 1; m_req = 1; c_addr = 5; m_addr = 6; c_we = 1; m_we = 1;
    rst = 1; step();
    n_tests++;
    if ({last_cg, last_mg, last_we, c_rvalid, m_rvalid, err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_state got gc/gm/we/crv/mrv/err=%b%b%b%b%b%b exp 000000",
               last_cg, last_mg, last_we, c_rvalid, m_rvalid, err);
    end
    rst = 0; c_we = 0; m_we = 0; step();
    n_tests++;
    if ({last_cg, last_mg} !== 2'b10) begin
      n_fail++;
      $display("FAIL first_conflict got gc/gm=%b%b exp 10", last_cg, last_mg);
    end
  endtask

  task automatic test_write_read();
    do_reset();
    c_req = 1; c_we = 1; c_addr = 28; c_wdata = 32'h20; step();
    n_tests++;
    if ({last_cg, last_we} !== 2'b11) begin
      n_fail++;
      $display("FAIL wr_gnt got gnt=%b we=%b exp 1 1", last_cg, last_we);
    end
    idle(); m_req = 1; m_addr = 28; step();
    idle(); step();
    // m_rvalid was checked by step at the previous negedge; recheck the held data
    n_tests++;
    if (m_rdata !== 32'h20) begin
      n_fail++;
      $display("FAIL rd_data got %h exp 00000020", m_rdata);
    end
  endtask

  task automatic test_alternate();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      c_req = 1; m_req = 1; c_we = 0; m_we = 0;
      c_addr = $urandom_range(0, DEPTH - 1); m_addr = $urandom_range(0, DEPTH - 1);
      step();
      n_tests++;
      if ({last_cg, last_mg} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL alternate i=%0d got gc/gm=%b%b", i, last_cg, last_mg);
      end
    end
  endtask

  task automatic test_burst();
    do_reset();
    c_req = 1; c_addr = 1; step();   // C takes the first slot, so M wins next
    m_req = 1; m_lock = 1; m_we = 1; m_addr = 3;
    for (int i = 0; i < 20; i++) begin
      m_wdata = $urandom;
      step();
      n_tests++;
      if ({last_cg, last_mg} !== ((i == 8 || i == 17) ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL burst i=%0d got gc/gm=%b%b", i, last_cg, last_mg);
      end
    end
  endtask

  task automatic test_oor();
    do_reset();
    c_req = 1; c_addr = 600; step();
    n_tests++;
    if ({last_cg, last_we} !== 2'b10) begin
      n_fail++;
      $display("FAIL oor_rd got gnt=%b we=%b exp 1 0", last_cg, last_we);
    end
    n_tests++;
    if ({c_rvalid, c_rdata, err} !== {1'b1, 32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL oor_ret got v=%b d=%h err=%b exp 1 0 1", c_rvalid, c_rdata, err);
    end
    c_we = 1; c_addr = 700; c_wdata = 32'h77; step();
    n_tests++;
    if (last_we !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_wr got we=%b exp 0", last_we);
    end
    idle();
    repeat (5) step();
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky got %b exp 1", err);
    end
    do_reset();
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear got %b exp 0", err);
    end
  endtask

  task automatic test_reset_squash();
    do_reset();
    c_req = 1; c_we = 1; c_addr = 28; c_wdata = 32'h55; step();
    idle(); m_req = 1; m_addr = 28; step();
    n_tests++;
    if ({m_rvalid, m_rdata} !== {1'b1, 32'h55}) begin
      n_fail++;
      $display("FAIL pre_squash got v=%b d=%h exp 1 00000055", m_rvalid, m_rdata);
    end
    c_req = 1; rst = 1; step();
    n_tests++;
    if ({last_cg, last_mg, m_rvalid, m_rdata} !== 35'd0) begin
      n_fail++;
      $display("FAIL squash got gc/gm=%b%b v=%b d=%h exp 0", last_cg, last_mg, m_rvalid, m_rdata);
    end
    rst = 0; step();
    n_tests++;
    if ({last_cg, last_mg} !== 2'b10) begin
      n_fail++;
      $display("FAIL post_squash got gc/gm=%b%b exp 10", last_cg, last_mg);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    c_req = 1; c_we = 1; c_addr = 40; c_wdata = 32'h2; step();
    idle(); m_req = 1; m_addr = 40; step();
    idle(); step();
    n_tests++;
    if (m_rdata !== 32'h2) begin
      n_fail++;
      $display("FAIL wr_then_rd got %h exp 00000002", m_rdata);
    end
    do_reset();
    c_req = 1; c_we = 1; c_addr = 40; c_wdata = 32'h5; m_req = 1; m_addr = 40; step();
    n_tests++;
    if ({last_cg, last_mg} !== 2'b10) begin
      n_fail++;
      $display("FAIL conflict_c got gc/gm=%b%b exp 10", last_cg, last_mg);
    end
    c_req = 0; step();
    n_tests++;
    if (last_mg !== 1'b1) begin
      n_fail++;
      $display("FAIL conflict_m got gm=%b exp 1", last_mg);
    end
    idle(); step();
    n_tests++;
    if (m_rdata !== 32'h5) begin
      n_fail++;
      $display("FAIL conflict_data got %h exp 00000005", m_rdata);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 60) == 0);
      c_req   = $urandom_range(0, 3) != 0;
      c_we    = $urandom_range(0, 1);
      c_addr  = $urandom_range(0, 540);
      c_wdata = $urandom;
      m_req   = $urandom_range(0, 4) != 0;
      m_we    = $urandom_range(0, 1);
      m_addr  = $urandom_range(0, 540);
      m_wdata = $urandom;
      m_lock  = $urandom_range(0, 3) != 0;
      step();
    end
    rst = 0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      env_mem[i]   = $urandom;
      model_mem[i] = env_mem[i];
    end
    idle();
    rst = 1;
    test_reset();
    test_write_read();
    test_alternate();
    test_burst();
    test_oor();
    test_reset_squash();
    test_conflict();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
